// File: rtl/sreg_out_ctrl_if.sv
// sreg_out_ctrl bus: start qualifiers in, datapath
// control and shift-register strobes out.
interface sreg_out_ctrl_if;
  logic        enable;
  logic        fifo_not_empty;
  logic [2:0]  cs_addr;
  logic        sclk_en;
  logic        latch;
  logic        busy;
  logic        word_done;
  logic [15:0] word_count;

  modport master (
    input  enable,
    input  fifo_not_empty,
    output cs_addr,
    output sclk_en,
    output latch,
    output busy,
    output word_done,
    output word_count
  );

  modport slave (
    output enable,
    output fifo_not_empty,
    input  cs_addr,
    input  sclk_en,
    input  latch,
    input  busy,
    input  word_done,
    input  word_count
  );
endinterface

// File: rtl/sreg_out_ctrl.sv
// Shift-register output sequencer: load a word from the
// datapath FIFO, shift it out, latch it, then idle a gap.
module sreg_out_ctrl #(
  parameter int WORD_BITS    = 32,
  parameter int GAP_CYCLES   = 2,
  parameter int LATCH_CYCLES = 1
) (
  input  logic clock,
  input  logic reset_n,
  sreg_out_ctrl_if.master bus
);

  if (WORD_BITS < 1 || WORD_BITS > 32) begin : g_bad_wb
    $error("sreg_out_ctrl: WORD_BITS must be 1..32");
  end
  if (GAP_CYCLES < 0 || GAP_CYCLES > 15) begin : g_bad_gap
    $error("sreg_out_ctrl: GAP_CYCLES must be 0..15");
  end
  if (LATCH_CYCLES < 1 || LATCH_CYCLES > 4) begin : g_bad_lat
    $error("sreg_out_ctrl: LATCH_CYCLES must be 1..4");
  end

  localparam logic [5:0] BIT_LAST = 6'(WORD_BITS - 1);
  localparam logic [3:0] LAT_LAST = 4'(LATCH_CYCLES - 1);
  localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);
  localparam bit         NO_GAP   = (GAP_CYCLES == 0);

  localparam logic [2:0] CS_HOLD  = 3'b000;
  localparam logic [2:0] CS_LOAD  = 3'b001;
  localparam logic [2:0] CS_SHIFT = 3'b010;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_LATCH,
    S_GAP
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  bit_q, bit_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] wc_q;
  logic        wc_inc;
  logic        go;

  logic [2:0]  cs_o;
  logic        sclk_o;
  logic        latch_o;
  logic        busy_o;
  logic        done_o;

  assign go = bus.enable && bus.fifo_not_empty;

  // State and counter registers
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      bit_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      cnt_q   <= cnt_d;
    end
  end

  // Completed-word counter, wraps naturally at 16 bits
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wc_q <= '0;
    end else if (wc_inc) begin
      wc_q <= wc_q + 16'd1;
    end
  end

  // Next state; start qualifiers only looked at in IDLE
  // and at the end of the word
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    cnt_d   = cnt_q;
    wc_inc  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (go) state_d = S_LOAD;
      end
      S_LOAD: begin
        state_d = S_SHIFT;
        bit_d   = '0;
      end
      S_SHIFT: begin
        if (bit_q == BIT_LAST) begin
          state_d = S_LATCH;
          cnt_d   = '0;
        end else begin
          bit_d = bit_q + 6'd1;
        end
      end
      S_LATCH: begin
        if (cnt_q == LAT_LAST) begin
          wc_inc = 1'b1;
          cnt_d  = '0;
          if (NO_GAP) begin
            state_d = go ? S_LOAD : S_IDLE;
          end else begin
            state_d = S_GAP;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = go ? S_LOAD : S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs decoded from state and counters only
  always_comb begin
    cs_o    = CS_HOLD;
    sclk_o  = 1'b0;
    latch_o = 1'b0;
    busy_o  = 1'b1;
    done_o  = 1'b0;
    unique case (1'b1)
      (state_q == S_IDLE): begin
        busy_o = 1'b0;
      end
      (state_q == S_LOAD): begin
        cs_o = CS_LOAD;
      end
      (state_q == S_SHIFT): begin
        cs_o   = CS_SHIFT;
        sclk_o = 1'b1;
      end
      (state_q == S_LATCH): begin
        latch_o = 1'b1;
        done_o  = (cnt_q == LAT_LAST);
      end
      default: begin
      end
    endcase
  end

  assign bus.cs_addr    = cs_o;
  assign bus.sclk_en    = sclk_o;
  assign bus.latch      = latch_o;
  assign bus.busy       = busy_o;
  assign bus.word_done  = done_o;
  assign bus.word_count = wc_q;

endmodule

// File: tb/tb_sreg_out_ctrl.sv
// Bench for sreg_out_ctrl: default and corner-parameter
// instances against a word-position reference model.
module tb_sreg_out_ctrl;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  logic en      = 1'b0;
  logic fne     = 1'b0;

  always #5 clock = ~clock;

  sreg_out_ctrl_if bus0 ();
  sreg_out_ctrl_if bus1 ();

  assign bus0.enable         = en;
  assign bus0.fifo_not_empty = fne;
  assign bus1.enable         = en;
  assign bus1.fifo_not_empty = fne;

  sreg_out_ctrl dut0 (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus0)
  );

  sreg_out_ctrl #(
    .WORD_BITS    (1),
    .GAP_CYCLES   (0),
    .LATCH_CYCLES (4)
  ) dut1 (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus1)
  );

  localparam int WB0 = 32, LC0 = 1, GC0 = 2;
  localparam int WB1 = 1,  LC1 = 4, GC1 = 0;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int pos0 = -1;
  int pos1 = -1;
  logic [15:0] wc0 = '0;
  logic [15:0] wc1 = '0;

  int loads0[$];
  int loads1[$];
  bit seen_done0;

  // Expected outputs from position within the word:
  // 0 = load, 1..wb = shift, then lc latch cycles, then gap.
  function automatic logic [22:0] expv(
    int pos, logic [15:0] wc, int wb, int lc);
    logic [2:0] cs;
    logic sc, la, bz, dn;
    sc = (pos >= 1) && (pos <= wb);
    cs = (pos == 0) ? 3'b001 : (sc ? 3'b010 : 3'b000);
    la = (pos > wb) && (pos <= wb + lc);
    bz = (pos >= 0);
    dn = (pos == wb + lc);
    return {cs, sc, la, bz, dn, wc};
  endfunction

  task automatic model_step(
    inout int pos, inout logic [15:0] wc,
    input int wb, input int lc, input int gc,
    input logic r, input logic e, input logic f);
    if (!r) begin
      pos = -1;
      wc  = '0;
    end else if (pos < 0) begin
      if (e && f) pos = 0;
    end else begin
      if (pos == wb + lc) wc = wc + 16'd1;
      if (pos == wb + lc + gc) pos = (e && f) ? 0 : -1;
      else pos = pos + 1;
    end
  endtask

  task automatic check(
    string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h",
             tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [22:0] obs0();
    return {bus0.cs_addr, bus0.sclk_en, bus0.latch,
            bus0.busy, bus0.word_done, bus0.word_count};
  endfunction

  function automatic logic [22:0] obs1();
    return {bus1.cs_addr, bus1.sclk_en, bus1.latch,
            bus1.busy, bus1.word_done, bus1.word_count};
  endfunction

  task automatic tick();
    logic r, e, f;
    r = reset_n;
    e = en;
    f = fne;
    @(posedge clock);
    model_step(pos0, wc0, WB0, LC0, GC0, r, e, f);
    model_step(pos1, wc1, WB1, LC1, GC1, r, e, f);
    #1;
    cyc++;
    check("out0", 32'(obs0()), 32'(expv(pos0, wc0, WB0, LC0)));
    check("out1", 32'(obs1()), 32'(expv(pos1, wc1, WB1, LC1)));
    if (bus0.cs_addr == 3'b001) loads0.push_back(cyc);
    if (bus1.cs_addr == 3'b001) loads1.push_back(cyc);
    if (bus0.word_done) seen_done0 = 1'b1;
  endtask

  initial begin
    // reset
    reset_n = 1'b0;
    repeat (3) tick();
    check("rst_busy", 32'(bus0.busy), 32'd0);
    check("rst_wc", 32'(bus0.word_count), 32'd0);
    reset_n = 1'b1;
    repeat (3) tick();

    // single word
    en  = 1'b1;
    fne = 1'b1;
    tick();
    fne = 1'b0;
    check("single_load", 32'(bus0.cs_addr), 32'h1);
    repeat (45) tick();
    check("single_wc", 32'(bus0.word_count), 32'd1);
    check("single_idle", 32'(bus0.busy), 32'd0);

    // back-to-back, three words on the default instance
    loads0.delete();
    loads1.delete();
    fne = 1'b1;
    repeat (100) tick();
    fne = 1'b0;
    repeat (40) tick();
    check("b2b_nloads", 32'(loads0.size()), 32'd3);
    for (int i = 1; i < loads0.size(); i++)
      check("b2b_period0", 32'(loads0[i] - loads0[i-1]), 32'd36);
    for (int i = 1; i < loads1.size(); i++)
      check("b2b_period1", 32'(loads1[i] - loads1[i-1]), 32'd6);
    check("b2b_wc", 32'(bus0.word_count), 32'd4);

    // enable drop on shift cycle 10
    fne = 1'b1;
    tick();
    repeat (10) tick();
    en = 1'b0;
    check("drop_shift", 32'(bus0.sclk_en), 32'd1);
    repeat (50) tick();
    check("drop_idle", 32'(bus0.busy), 32'd0);
    check("drop_wc", 32'(bus0.word_count), 32'd5);

    // reset on shift cycle 5
    en = 1'b1;
    tick();
    repeat (5) tick();
    reset_n = 1'b0;
    tick();
    check("rmid_cs", 32'(bus0.cs_addr), 32'd0);
    check("rmid_busy", 32'(bus0.busy), 32'd0);
    check("rmid_wc", 32'(bus0.word_count), 32'd0);
    check("rmid_latch", 32'(bus0.latch), 32'd0);
    reset_n = 1'b1;
    tick();
    check("rmid_reload", 32'(bus0.cs_addr), 32'h1);
    repeat (10) tick();

    // randomized traffic with occasional resets
    repeat (3000) begin
      en      = ($urandom_range(0, 3) != 0);
      fne     = 1'($urandom);
      reset_n = ($urandom_range(0, 199) != 0);
      tick();
    end
    reset_n = 1'b1;

    // word_count wrap
    en  = 1'b0;
    fne = 1'b0;
    repeat (40) tick();
    force dut0.wc_q = 16'hFFFF;
    wc0 = 16'hFFFF;
    tick();
    release dut0.wc_q;
    tick();
    check("wrap_pre", 32'(bus0.word_count), 32'hFFFF);
    seen_done0 = 1'b0;
    en  = 1'b1;
    fne = 1'b1;
    tick();
    fne = 1'b0;
    repeat (45) tick();
    check("wrap_wc", 32'(bus0.word_count), 32'h0);
    check("wrap_done", 32'(seen_done0), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
